ds_scoreboard: RTL and testbench

Parametrised register scoreboard for the decode stage of the in-order pipeline. It counts in-flight writes per architectural register, so the decode stall decision no longer depends on a fixed es/ms/ws forwarding depth. It tracks every issued writer until write-back, including multi-cycle producers such as loads and mul/div. Decode issues into it and write-back retires from it; a pipeline flush clears it.

---
 rtl/ds_scoreboard.sv | 127 ++++++++++++
 tb/tb_ds_scoreboard.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_scoreboard.sv
// ds_scoreboard: per-register in-flight write counters for the decode stage.
// Decode issues writers into it, write-back retires them, flush clears them.
// The stall/issue handshake is purely combinational on the current inputs and
// the registered counters, with a same-cycle write-back bypass for readers.
module ds_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [AW-1:0]     issue_dest,
    input  logic [NRD-1:0]    rd_need,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_dest,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic [NREG-1:0]   busy,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Register 0 is hard-wired zero, so it has no counter at all.
    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [NRD-1:0]   src_stall;
    logic [AW-1:0]    src_a;
    logic             sat_stall;
    logic             illegal_retire;
    logic             inc;
    logic             dec;

    // Counter lookup by address; address 0 (and any address >= NREG) reads 0.
    function automatic logic [CNT_W-1:0] cnt_at(input logic [AW-1:0] a);
        logic [CNT_W-1:0] v;
        v = '0;
        for (int r = 1; r < NREG; r++) begin
            if (a == AW'(r)) begin
                v = cnt_q[r];
            end
        end
        return v;
    endfunction

    // A source is ready when nothing is in flight, or the only writer retires now.
    function automatic logic src_ready(input logic [AW-1:0] a);
        logic [CNT_W-1:0] c;
        c = cnt_at(a);
        return (a == '0) || (c == '0) ||
               ((c == CNT_ONE) && wb_we && (wb_dest == a));
    endfunction

    // Decode handshake: source hazards, counter saturation, then acceptance.
    always_comb begin
        src_stall = '0;
        src_a     = '0;
        for (int i = 0; i < NRD; i++) begin
            src_a        = rd_addr[i*AW +: AW];
            src_stall[i] = rd_need[i] & ~src_ready(src_a);
        end
        sat_stall  = issue_we && (issue_dest != '0) &&
                     (cnt_at(issue_dest) == CNT_MAX) &&
                     !(wb_we && (wb_dest == issue_dest));
        stall      = issue_valid & ((|src_stall) | sat_stall);
        issue_fire = issue_valid & ~stall & ~flush;
    end

    // Next counter values and sticky error; flush wins over issue and retire.
    always_comb begin
        illegal_retire = wb_we && (wb_dest != '0) && (cnt_at(wb_dest) == '0);
        sb_err_d       = sb_err_q | illegal_retire;
        inc            = 1'b0;
        dec            = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            inc      = issue_fire && issue_we && (issue_dest == AW'(r));
            dec      = wb_we && (wb_dest == AW'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

    // Busy view of the registered counters; bit 0 is permanently clear.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy[gi] = 1'b0;
            end else begin : g_reg
                assign busy[gi] = (cnt_q[gi] != '0);
            end
        end
    endgenerate

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_ds_scoreboard.sv
// Testbench for ds_scoreboard: directed scenarios plus randomized traffic,
// predicted by a count-per-register reference model and checked through a
// queue of expected outputs consumed by an independent monitor.
module tb_ds_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic [1:0]  rd_need = '0;
    logic [9:0]  rd_addr = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy;
    logic        sb_err;

    ds_scoreboard #(.NREG(32), .AW(5), .NRD(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
        .rd_need(rd_need), .rd_addr(rd_addr),
        .wb_we(wb_we), .wb_dest(wb_dest), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: number of outstanding writes per register.
    int cnt_m[32];
    bit err_m = 1'b0;
    bit exp_stall = 1'b0;
    bit exp_fire = 1'b0;
    localparam int MAXC = 3;

    function automatic bit ready_m(input logic [4:0] a);
        return (a == 0) || (cnt_m[a] == 0) ||
               (cnt_m[a] == 1 && wb_we && wb_dest == a);
    endfunction

    // Predict the combinational handshake for the inputs now being driven.
    function automatic void predict();
        bit hazard;
        hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [4:0] a;
            a = rd_addr[i*5 +: 5];
            if (rd_need[i] && !ready_m(a)) hazard = 1'b1;
        end
        if (issue_we && issue_dest != 0 && cnt_m[issue_dest] == MAXC &&
            !(wb_we && wb_dest == issue_dest)) hazard = 1'b1;
        exp_stall = issue_valid && hazard;
        exp_fire  = issue_valid && !exp_stall && !flush;
    endfunction

    function automatic logic [31:0] busy_m();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (cnt_m[r] != 0);
        return b;
    endfunction

    // Apply what the clock edge does with the inputs held during the last cycle.
    function automatic void model_step();
        int old_wb;
        old_wb = cnt_m[wb_dest];
        if (wb_we && wb_dest != 0 && old_wb == 0) err_m = 1'b1;
        if (flush) begin
            for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        end else begin
            if (exp_fire && issue_we && issue_dest != 0) cnt_m[issue_dest]++;
            if (wb_we && wb_dest != 0 && old_wb != 0) cnt_m[wb_dest]--;
        end
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.stall = exp_stall;
        e.fire  = exp_fire;
        e.busy  = busy_m();
        e.err   = err_m;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endfunction

    task automatic cyc(input string tag, input bit iv, input bit we,
                       input logic [4:0] dest, input logic [1:0] need,
                       input logic [9:0] addr, input bit wbw,
                       input logic [4:0] wbd, input bit fl);
        @(posedge clk);
        model_step();
        #1;
        issue_valid = iv; issue_we = we; issue_dest = dest;
        rd_need = need; rd_addr = addr;
        wb_we = wbw; wb_dest = wbd; flush = fl;
        predict();
        push_exp(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 5'd0, 2'b00, 10'd0, 0, 5'd0, 0);
    endtask

    task automatic issue_w(input string tag, input logic [4:0] d);
        cyc(tag, 1, 1, d, 2'b00, 10'd0, 0, 5'd0, 0);
    endtask

    task automatic retire(input string tag, input logic [4:0] d);
        cyc(tag, 0, 0, 5'd0, 2'b00, 10'd0, 1, d, 0);
    endtask

    // Reset asserted between clock edges, held across one edge.
    task automatic mid_reset(input string tag);
        @(posedge clk);
        model_step();
        #2;
        reset = 1'b1;
        issue_valid = 0; issue_we = 0; issue_dest = 0; rd_need = 0;
        rd_addr = 0; wb_we = 0; wb_dest = 0; flush = 0;
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 1'b0;
        predict();
        push_exp(tag);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s [%s]: got %h required %h", name, tag, act, want);
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk("stall", t, {31'd0, stall}, {31'd0, e.stall});
            chk("issue_fire", t, {31'd0, issue_fire}, {31'd0, e.fire});
            chk("busy", t, busy, e.busy);
            chk("sb_err", t, {31'd0, sb_err}, {31'd0, e.err});
            $display("cyc %s: stall=%0b fire=%0b busy=%h err=%0b", t,
                     stall, issue_fire, busy, sb_err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset then idle
        idle("reset_idle");
        cyc("idle_issue", 1, 0, 5'd0, 2'b11, {5'd3, 5'd7}, 0, 5'd0, 0);

        // RAW with write-back bypass
        issue_w("raw_prod", 5'd5);
        for (int k = 0; k < 3; k++)
            cyc("raw_wait", 1, 0, 5'd0, 2'b01, {5'd0, 5'd5}, 0, 5'd0, 0);
        cyc("raw_bypass", 1, 0, 5'd0, 2'b01, {5'd0, 5'd5}, 1, 5'd5, 0);
        idle("raw_after");

        // Saturation of r9
        for (int k = 0; k < 3; k++) issue_w("sat_fill", 5'd9);
        issue_w("sat_full", 5'd9);
        cyc("sat_retire", 1, 1, 5'd9, 2'b00, 10'd0, 1, 5'd9, 0);
        for (int k = 0; k < 3; k++) retire("sat_drain", 5'd9);
        idle("sat_empty");

        // Simultaneous issue and retire of r4
        issue_w("r4_issue", 5'd4);
        cyc("r4_both", 1, 1, 5'd4, 2'b00, 10'd0, 1, 5'd4, 0);
        idle("r4_hold");
        retire("r4_drain", 5'd4);

        // Flush with busy = 0x0000_0C30
        issue_w("fl_fill", 5'd4);
        issue_w("fl_fill", 5'd5);
        issue_w("fl_fill", 5'd10);
        issue_w("fl_fill", 5'd11);
        cyc("flush", 1, 1, 5'd6, 2'b00, 10'd0, 0, 5'd0, 1);
        idle("flush_after");

        // r0 and illegal retire
        issue_w("r0_issue", 5'd0);
        retire("r0_retire", 5'd0);
        idle("r0_after");
        retire("bad_retire", 5'd12);
        idle("err_set");
        issue_w("err_fill", 5'd3);
        cyc("err_flush", 0, 0, 5'd0, 2'b00, 10'd0, 0, 5'd0, 1);
        idle("err_sticky");
        issue_w("pre_reset", 5'd7);
        issue_w("pre_reset", 5'd8);
        mid_reset("mid_reset");
        cyc("post_reset", 1, 1, 5'd7, 2'b11, {5'd7, 5'd8}, 0, 5'd0, 0);

        // Randomized traffic; issue and source fields held while stalled
        begin
            bit         iv = 0, we = 0, wbw, fl;
            logic [4:0] dest = 0, wbd;
            logic [1:0] need = 0;
            logic [9:0] addr = 0;
            for (int k = 0; k < 2000; k++) begin
                if (k == 1000) mid_reset("rand_reset");
                if (!(exp_stall && issue_valid)) begin
                    iv   = ($urandom % 4) != 0;
                    we   = ($urandom % 3) != 0;
                    dest = 5'($urandom % 8);
                    need = 2'($urandom % 4);
                    addr = {5'($urandom % 8), 5'($urandom % 8)};
                end
                wbd = 5'(1 + $urandom % 7);
                if (cnt_m[wbd] > 0 && ($urandom % 2) == 0) begin
                    wbw = 1;
                end else if (($urandom % 150) == 0) begin
                    wbw = 1;
                    wbd = 5'($urandom % 16);
                end else begin
                    wbw = 0;
                end
                fl = ($urandom % 40) == 0;
                cyc("rand", iv, we, dest, need, addr, wbw, wbd, fl);
            end
        end

        @(negedge clk);
        #1;
        chk("drain", "end", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
